// File: rtl/core_pkg.sv
// Shared types and constants for the fetch-address generator and its redirect selector.
package core_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    HALT = 2'd3
  } pc_state_e;

  // Redirect source indices; a lower index wins when several fire together.
  localparam int unsigned RED_TRAP = 0;
  localparam int unsigned RED_EX   = 1;
  localparam int unsigned RED_ID   = 2;

  localparam int unsigned STEP_HALF = 2;
  localparam int unsigned STEP_WORD = 4;

  function automatic bit step_is_legal(input int unsigned step);
    return (step == STEP_HALF) || (step == STEP_WORD);
  endfunction

  // Number of low address bits cleared when aligning a redirect target.
  function automatic int unsigned align_bits(input int unsigned step);
    return (step == STEP_HALF) ? 1 : 2;
  endfunction

endpackage

// File: rtl/pc_redir_sel.sv
// Priority encoder over the redirect sources plus target aligner.
module pc_redir_sel
  import core_pkg::*;
#(
  parameter int unsigned AW   = 32,
  parameter int unsigned NRED = 3,
  parameter int unsigned STEP = 4
) (
  input  logic [NRED-1:0]    redir_valid,
  input  logic [NRED*AW-1:0] redir_addr,
  output logic               sel_valid,
  output logic [AW-1:0]      sel_addr,
  output logic               sel_misalign
);

  localparam int unsigned    ALIGN      = align_bits(STEP);
  localparam logic [AW-1:0]  ALIGN_MASK = AW'((1 << ALIGN) - 1);

  logic [AW-1:0] raw_addr;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    sel_valid = 1'b0;
    raw_addr  = '0;
    // Walk from the lowest-priority source down so index 0 is written last.
    for (int i = NRED - 1; i >= 0; i--) begin
      if (redir_valid[i]) begin
        sel_valid = 1'b1;
        raw_addr  = redir_addr[i*AW +: AW];
      end
    end
  end

  assign sel_addr     = raw_addr & ~ALIGN_MASK;
  assign sel_misalign = sel_valid & (|(raw_addr & ALIGN_MASK));

endmodule

// File: rtl/pc_gen.sv
// Fetch-address generator: PC, epoch tag and fetch request channel with redirect,
// stall and halt control.
`ifndef PC_RST_ADDR
`define PC_RST_ADDR 32'h0000_0000
`endif

module pc_gen
  import core_pkg::*;
#(
  parameter int unsigned   AW       = 32,
  parameter logic [AW-1:0] RST_ADDR = AW'(`PC_RST_ADDR),
  parameter int unsigned   NRED     = 3,
  parameter int unsigned   STEP     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NRED-1:0]    redir_valid,
  input  logic [NRED*AW-1:0] redir_addr,
  input  logic               stall,
  input  logic               halt,
  input  logic               resume,
  output logic               req_valid,
  input  logic               req_ready,
  output logic [AW-1:0]      req_addr,
  output logic               req_epoch,
  output logic               misalign_err,
  output logic               halted
);

  localparam logic [AW-1:0] STEP_INC = AW'(STEP);

  pc_state_e     state;
  logic [AW-1:0] pc;
  logic [AW-1:0] pend;
  logic          epoch;
  logic          held;

  logic          sel_valid;
  logic [AW-1:0] sel_addr;
  logic          sel_misalign;
  logic          fire;
  logic          waiting;

  pc_redir_sel #(
    .AW   (AW),
    .NRED (NRED),
    .STEP (STEP)
  ) u_redir_sel (
    .redir_valid  (redir_valid),
    .redir_addr   (redir_addr),
    .sel_valid    (sel_valid),
    .sel_addr     (sel_addr),
    .sel_misalign (sel_misalign)
  );

  // A raised request must stay up until accepted, hence held overrides stall.
  always_comb begin
    req_valid = 1'b0;
    unique case (state)
      RUN:     req_valid = held | ~stall;
      HOLD:    req_valid = 1'b1;
      default: req_valid = 1'b0;
    endcase
  end

  assign fire      = req_valid & req_ready;
  assign waiting   = req_valid & ~req_ready;
  assign req_addr  = pc;
  assign req_epoch = epoch;
  assign halted    = (state == HALT);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= RST_ADDR;
      pend         <= '0;
      epoch        <= 1'b0;
      held         <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      held         <= waiting;
      misalign_err <= 1'b0;
      unique case (state)
        IDLE: state <= RUN;
        RUN: begin
          if (sel_valid && waiting) begin
            // Outstanding request must not move; park the target until it fires.
            pend         <= sel_addr;
            misalign_err <= sel_misalign;
            state        <= HOLD;
          end else begin
            if (sel_valid) begin
              pc           <= sel_addr;
              epoch        <= ~epoch;
              misalign_err <= sel_misalign;
            end else if (fire) begin
              pc <= pc + STEP_INC;
            end
            if (halt && !waiting) state <= HALT;
          end
        end
        HOLD: begin
          if (fire) begin
            pc    <= sel_valid ? sel_addr : pend;
            epoch <= ~epoch;
            state <= RUN;
            if (sel_valid) misalign_err <= sel_misalign;
          end else if (sel_valid) begin
            pend         <= sel_addr;
            misalign_err <= sel_misalign;
          end
        end
        HALT: begin
          if (sel_valid) begin
            pc           <= sel_addr;
            epoch        <= ~epoch;
            misalign_err <= sel_misalign;
          end
          if (resume) state <= RUN;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: stimulus pushes expected fetches into a queue,
// a monitor pops and compares on every accepted request.
module tb_pc_gen;
  import core_pkg::*;

  localparam int unsigned   AW       = 32;
  localparam int unsigned   NRED     = 3;
  localparam logic [31:0]   RST_ADDR = 32'h0000_1000;

  typedef struct {
    logic [31:0] addr;
    logic        epoch;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic [NRED-1:0]    redir_valid;
  logic [NRED*AW-1:0] redir_addr;
  logic               stall, halt, resume, req_ready;

  logic               req_valid, req_epoch, misalign_err, halted;
  logic [AW-1:0]      req_addr;
  logic               req_valid2, req_epoch2, misalign_err2, halted2;
  logic [AW-1:0]      req_addr2;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  pc_gen #(.AW(AW), .RST_ADDR(RST_ADDR), .NRED(NRED), .STEP(4)) u_dut4 (
    .clk(clk), .rst(rst), .redir_valid(redir_valid), .redir_addr(redir_addr),
    .stall(stall), .halt(halt), .resume(resume), .req_valid(req_valid),
    .req_ready(req_ready), .req_addr(req_addr), .req_epoch(req_epoch),
    .misalign_err(misalign_err), .halted(halted)
  );

  pc_gen #(.AW(AW), .RST_ADDR(RST_ADDR), .NRED(NRED), .STEP(2)) u_dut2 (
    .clk(clk), .rst(rst), .redir_valid(redir_valid), .redir_addr(redir_addr),
    .stall(stall), .halt(halt), .resume(resume), .req_valid(req_valid2),
    .req_ready(req_ready), .req_addr(req_addr2), .req_epoch(req_epoch2),
    .misalign_err(misalign_err2), .halted(halted2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] addr, input logic epoch);
    exp_t e;
    e.addr  = addr;
    e.epoch = epoch;
    exp_q.push_back(e);
  endtask

  task automatic set_redir(input int unsigned src, input logic [31:0] addr);
    redir_valid[src]           = 1'b1;
    redir_addr[src*AW +: AW]   = addr;
  endtask

  task automatic clr_redir();
    redir_valid = '0;
    redir_addr  = '0;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic summary();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
  endtask

  // Monitor: every accepted request must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!rst && req_valid && req_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_fire: got addr 0x%08h epoch %0b, expected none", req_addr, req_epoch);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("fire_addr", req_addr, e.addr);
        check("fire_epoch", 32'(req_epoch), 32'(e.epoch));
      end
    end
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    summary();
    $finish;
  end

  initial begin
    rst = 1'b1; stall = 1'b0; halt = 1'b0; resume = 1'b0; req_ready = 1'b1;
    clr_redir();
    next(); next();
    mid();
    check("rst_valid", 32'(req_valid), 0);
    check("rst_addr", req_addr, RST_ADDR);
    check("rst_epoch", 32'(req_epoch), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_misalign", 32'(misalign_err), 0);
    next();
    rst = 1'b0;

    // T1: IDLE, no request yet
    mid(); check("idle_valid", 32'(req_valid), 0); next();
    // T2..T4: back-to-back fires
    push(RST_ADDR, 1'b0);     mid(); next();
    push(RST_ADDR + 4, 1'b0); mid(); next();
    push(RST_ADDR + 8, 1'b0); mid(); next();

    // T5..T7: request waits while stall toggles
    req_ready = 1'b0;
    mid(); check("wait_valid0", 32'(req_valid), 1); check("wait_addr0", req_addr, RST_ADDR + 12); next();
    stall = 1'b1;
    mid(); check("wait_valid1", 32'(req_valid), 1); check("wait_addr1", req_addr, RST_ADDR + 12); next();
    stall = 1'b0;
    mid(); check("wait_valid2", 32'(req_valid), 1); check("wait_epoch2", 32'(req_epoch), 0); next();
    // T8: accepted under stall
    stall = 1'b1; req_ready = 1'b1;
    push(RST_ADDR + 12, 1'b0); mid(); next();
    // T9: stall blocks a fresh request
    mid(); check("stall_valid", 32'(req_valid), 0); check("stall_addr", req_addr, RST_ADDR + 16); next();

    // T10: fire with simultaneous redirect; src1 beats src2
    stall = 1'b0;
    set_redir(RED_EX, 32'h200); set_redir(RED_ID, 32'h300);
    push(RST_ADDR + 16, 1'b0); mid(); next();
    clr_redir();
    // T11
    push(32'h200, 1'b1); mid(); check("redir_misalign0", 32'(misalign_err), 0); next();

    // T12..T16: redirects parked while the request waits; latest wins
    req_ready = 1'b0;
    mid(); next();
    set_redir(RED_TRAP, 32'h400);
    mid(); next();
    clr_redir(); set_redir(RED_ID, 32'h500);
    mid(); check("hold_addr", req_addr, 32'h204); check("hold_epoch", 32'(req_epoch), 1); next();
    clr_redir(); req_ready = 1'b1;
    push(32'h204, 1'b1); mid(); next();
    push(32'h500, 1'b0); mid(); next();

    // T17..T19: misaligned redirect while idle-stalled
    stall = 1'b1; req_ready = 1'b0;
    set_redir(RED_EX, 32'h103);
    mid(); next();
    clr_redir();
    mid();
    check("mis4_addr", req_addr, 32'h100);
    check("mis4_err", 32'(misalign_err), 1);
    check("mis2_addr", req_addr2, 32'h102);
    check("mis2_err", 32'(misalign_err2), 1);
    next();
    halt = 1'b1;
    mid(); check("mis4_pulse", 32'(misalign_err), 0); check("mis2_pulse", 32'(misalign_err2), 0); next();

    // T20..T22: redirect while halted, then resume
    halt = 1'b0; stall = 1'b0; req_ready = 1'b1;
    set_redir(RED_ID, 32'h800);
    mid(); check("halt_halted", 32'(halted), 1); check("halt_valid", 32'(req_valid), 0); next();
    clr_redir(); resume = 1'b1;
    mid(); check("halt_addr", req_addr, 32'h800); check("halt_valid1", 32'(req_valid), 0); next();
    resume = 1'b0;
    push(32'h800, 1'b0); mid(); check("resume_halted", 32'(halted), 0); next();

    // T23..T25: wrap at the top of the address space
    set_redir(RED_TRAP, 32'hFFFF_FFFC);
    push(32'h804, 1'b0); mid(); next();
    clr_redir();
    push(32'hFFFF_FFFC, 1'b1); mid(); next();
    push(32'h0, 1'b1); mid(); check("wrap_addr", req_addr, 32'h0); next();

    // T26: async reset drops an outstanding request
    req_ready = 1'b0;
    mid(); check("pre_rst_valid", 32'(req_valid), 1); check("pre_rst_addr", req_addr, 32'h4);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(req_valid), 0);
    check("arst_addr", req_addr, RST_ADDR);
    check("arst_epoch", 32'(req_epoch), 0);
    next(); next();
    check("queue_empty", 32'(exp_q.size()), 0);
    summary();
    $finish;
  end

endmodule
